// File: rtl/wb_result_arbiter.sv
// Writeback result arbiter: per-source FIFOs feeding one registered writeback port.
// Define WB_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module wb_result_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic [NUM_SRC-1:0]    src_valid_i,
  input  logic [NUM_SRC-1:0]    src_we_i,
  input  logic [NUM_SRC*5-1:0]  src_dst_i,
  input  logic [NUM_SRC*64-1:0] src_data_i,
  output logic [NUM_SRC-1:0]    src_ready_o,
  output logic [63:0]           wb_data_o,
  output logic [4:0]            wb_dst_o,
  output logic                  wb_we_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(NUM_SRC);

  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    logic [63:0] data;
  } wb_entry_t;

  wb_entry_t     mem    [NUM_SRC][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [NUM_SRC];
  logic [AW-1:0] rd_ptr [NUM_SRC];
  logic [CW-1:0] count  [NUM_SRC];

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               gnt_vld;
  logic [PW-1:0]      gnt_idx;
  wb_entry_t          head;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      full[i]  = (count[i] == CW'(FIFO_DEPTH));
      empty[i] = (count[i] == '0);
    end
  end

  // Ready comes from the registered count only, so a full FIFO rejects even when it pops.
  assign src_ready_o = rstn_i ? ~full : '0;
  assign push        = src_valid_i & src_ready_o;

`ifdef WB_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (!empty[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end
`else
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cand;

  // Search starts one past the last winner and wraps.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      cand = PW'((int'(rr_ptr) + off) % NUM_SRC);
      if (!gnt_vld && !empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) rr_ptr <= PW'(NUM_SRC - 1);
    else if (gnt_vld)       rr_ptr <= gnt_idx;
  end
`endif

  always_comb begin
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  assign head = mem[gnt_idx][rd_ptr[gnt_idx]];

  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CW'(1);
          2'b01:   count[i] <= count[i] - CW'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // NOTE: FIFO storage is not reset; the counts alone decide which entries are valid.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= {src_we_i[i], src_dst_i[5*i +: 5], src_data_i[64*i +: 64]};
    end
  end

  // x0 never raises the write enable, keeping it out of the bypass network.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wb_we_o   <= 1'b0;
      wb_dst_o  <= '0;
      wb_data_o <= '0;
    end else if (flush_i) begin
      wb_we_o <= 1'b0;
    end else if (gnt_vld) begin
      wb_we_o   <= head.we & (head.dst != 5'd0);
      wb_dst_o  <= head.dst;
      wb_data_o <= head.data;
    end else begin
      wb_we_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_result_arbiter.sv
// Self-checking bench for wb_result_arbiter: reset, single result, x0, round-robin,
// full FIFO backpressure under streaming, and flush.
module tb_wb_result_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  dst;
    logic [63:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn_i;
  logic            flush_i;
  logic [N-1:0]    src_valid_i;
  logic [N-1:0]    src_we_i;
  logic [N*5-1:0]  src_dst_i;
  logic [N*64-1:0] src_data_i;
  logic [N-1:0]    src_ready_o;
  logic [63:0]     wb_data_o;
  logic [4:0]      wb_dst_o;
  logic            wb_we_o;

  int tests = 0;
  int fails = 0;

  exp_t ord_q[$];
  exp_t q0[$];
  exp_t q2[$];

  wb_result_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(2)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .flush_i    (flush_i),
    .src_valid_i(src_valid_i),
    .src_we_i   (src_we_i),
    .src_dst_i  (src_dst_i),
    .src_data_i (src_data_i),
    .src_ready_o(src_ready_o),
    .wb_data_o  (wb_data_o),
    .wb_dst_o   (wb_dst_o),
    .wb_we_o    (wb_we_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    src_valid_i = '0;
    src_we_i    = '0;
    src_dst_i   = '0;
    src_data_i  = '0;
    flush_i     = 1'b0;
  endtask

  task automatic set_src(input int s, input logic we, input logic [4:0] dst, input logic [63:0] data);
    src_valid_i[s]       = 1'b1;
    src_we_i[s]          = we;
    src_dst_i[s*5 +: 5]  = dst;
    src_data_i[s*64 +: 64] = data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn_i = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn_i = 1'b0;
    drive_idle();
    flush_i     = 1'b1;
    src_valid_i = '1;
    repeat (3) @(negedge clk);
    tests++; if (wb_we_o !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", wb_we_o); end
    tests++; if (wb_dst_o !== 5'd0) begin fails++; $display("FAIL reset_dst: got %0d want 0", wb_dst_o); end
    tests++; if (wb_data_o !== 64'd0) begin fails++; $display("FAIL reset_data: got %h want 0", wb_data_o); end
    tests++; if (src_ready_o !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", src_ready_o); end
    drive_idle();
    rstn_i = 1'b1;
    #1;
    tests++; if (src_ready_o !== 4'b1111) begin fails++; $display("FAIL release_ready: got %b want 1111", src_ready_o); end
    @(negedge clk);
    tests++; if (wb_we_o !== 1'b0) begin fails++; $display("FAIL release_we: got %b want 0", wb_we_o); end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_src(1, 1'b1, 5'd5, 64'hDEAD);
    @(negedge clk);
    drive_idle();
    tests++; if (wb_we_o !== 1'b0) begin fails++; $display("FAIL single_early: got we=%b want 0", wb_we_o); end
    @(negedge clk);
    tests++;
    if (wb_we_o !== 1'b1 || wb_dst_o !== 5'd5 || wb_data_o !== 64'hDEAD) begin
      fails++;
      $display("FAIL single_wb: got we=%b dst=%0d data=%h want we=1 dst=5 data=dead", wb_we_o, wb_dst_o, wb_data_o);
    end
    @(negedge clk);
    tests++;
    if (wb_we_o !== 1'b0 || wb_dst_o !== 5'd5) begin
      fails++;
      $display("FAIL single_hold: got we=%b dst=%0d want we=0 dst=5", wb_we_o, wb_dst_o);
    end
  endtask

  task automatic test_x0();
    @(negedge clk);
    set_src(0, 1'b1, 5'd0, 64'h1);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    tests++;
    if (wb_we_o !== 1'b0 || wb_dst_o !== 5'd0 || wb_data_o !== 64'h1) begin
      fails++;
      $display("FAIL x0_write: got we=%b dst=%0d data=%h want we=0 dst=0 data=1", wb_we_o, wb_dst_o, wb_data_o);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    do_reset();
    @(negedge clk);
    for (int s = 0; s < N; s++) begin
      set_src(s, 1'b1, 5'(s + 1), 64'h100 + 64'(s));
      ord_q.push_back('{we: 1'b1, dst: 5'(s + 1), data: 64'h100 + 64'(s)});
    end
    @(negedge clk);
    drive_idle();
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      e = ord_q.pop_front();
      tests++;
      if (wb_we_o !== e.we || wb_dst_o !== e.dst || wb_data_o !== e.data) begin
        fails++;
        $display("FAIL rr_order[%0d]: got we=%b dst=%0d data=%h want we=%b dst=%0d data=%h",
                 c, wb_we_o, wb_dst_o, wb_data_o, e.we, e.dst, e.data);
      end
    end
    set_src(0, 1'b1, 5'd10, 64'h200);
    set_src(3, 1'b1, 5'd13, 64'h203);
    ord_q.push_back('{we: 1'b1, dst: 5'd10, data: 64'h200});
    ord_q.push_back('{we: 1'b1, dst: 5'd13, data: 64'h203});
    @(negedge clk);
    drive_idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      e = ord_q.pop_front();
      tests++;
      if (wb_we_o !== e.we || wb_dst_o !== e.dst || wb_data_o !== e.data) begin
        fails++;
        $display("FAIL rr_refill[%0d]: got we=%b dst=%0d data=%h want we=%b dst=%0d data=%h",
                 c, wb_we_o, wb_dst_o, wb_data_o, e.we, e.dst, e.data);
      end
    end
    @(negedge clk);
    tests++; if (wb_we_o !== 1'b0) begin fails++; $display("FAIL rr_idle: got we=%b want 0", wb_we_o); end
  endtask

  task automatic test_full_stream();
    exp_t e;
    exp_t nx;
    int   sent0;
    int   sent2;
    bit   chk_full;
    bit   done;
    sent0    = 0;
    sent2    = 0;
    chk_full = 1'b0;
    done     = 1'b0;
    do_reset();
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (wb_we_o === 1'b1) begin
        tests++;
        if (wb_data_o[63:56] == 8'd0 && q0.size() > 0) begin
          e = q0.pop_front();
          if (wb_dst_o !== e.dst || wb_data_o !== e.data) begin
            fails++;
            $display("FAIL stream_src0: got dst=%0d data=%h want dst=%0d data=%h", wb_dst_o, wb_data_o, e.dst, e.data);
          end
        end else if (wb_data_o[63:56] == 8'd2 && q2.size() > 0) begin
          e = q2.pop_front();
          if (wb_dst_o !== e.dst || wb_data_o !== e.data) begin
            fails++;
            $display("FAIL stream_src2: got dst=%0d data=%h want dst=%0d data=%h", wb_dst_o, wb_data_o, e.dst, e.data);
          end
        end else begin
          fails++;
          $display("FAIL stream_unexpected: got dst=%0d data=%h with nothing pending", wb_dst_o, wb_data_o);
        end
      end
      if (chk_full) begin
        tests++;
        if (src_ready_o[2] !== 1'b0) begin fails++; $display("FAIL full_ready2: got %b want 0", src_ready_o[2]); end
        chk_full = 1'b0;
      end
      drive_idle();
      if (sent0 < 6) set_src(0, 1'b1, 5'(1 + sent0), {8'd0, 24'd0, 32'(sent0)});
      if (sent2 < 3) set_src(2, 1'b1, 5'(20 + sent2), {8'd2, 24'd0, 32'(sent2)});
      #1;
      if (src_valid_i[0] && src_ready_o[0]) begin
        nx = '{we: 1'b1, dst: 5'(1 + sent0), data: {8'd0, 24'd0, 32'(sent0)}};
        q0.push_back(nx);
        sent0++;
      end
      if (src_valid_i[2] && src_ready_o[2]) begin
        nx = '{we: 1'b1, dst: 5'(20 + sent2), data: {8'd2, 24'd0, 32'(sent2)}};
        q2.push_back(nx);
        sent2++;
        if (sent2 == 2) chk_full = 1'b1;
      end
      done = (sent0 == 6) && (sent2 == 3) && (q0.size() == 0) && (q2.size() == 0);
    end
    drive_idle();
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL stream_drain: sent0=%0d sent2=%0d pending0=%0d pending2=%0d want 6 3 0 0",
               sent0, sent2, q0.size(), q2.size());
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int   bad;
    do_reset();
    @(negedge clk);
    set_src(0, 1'b1, 5'd7, 64'h300);
    set_src(1, 1'b1, 5'd8, 64'h301);
    ord_q.push_back('{we: 1'b1, dst: 5'd7, data: 64'h300});
    @(negedge clk);
    drive_idle();
    set_src(1, 1'b1, 5'd9, 64'h302);
    @(negedge clk);
    drive_idle();
    e = ord_q.pop_front();
    tests++;
    if (wb_we_o !== e.we || wb_dst_o !== e.dst || wb_data_o !== e.data) begin
      fails++;
      $display("FAIL flush_pre: got we=%b dst=%0d data=%h want we=1 dst=%0d data=%h",
               wb_we_o, wb_dst_o, wb_data_o, e.dst, e.data);
    end
    flush_i = 1'b1;
    set_src(3, 1'b1, 5'd11, 64'h303);
    #1;
    tests++; if (src_ready_o !== 4'b1101) begin fails++; $display("FAIL flush_ready: got %b want 1101", src_ready_o); end
    @(negedge clk);
    drive_idle();
    tests++; if (wb_we_o !== 1'b0) begin fails++; $display("FAIL flush_we: got %b want 0", wb_we_o); end
    tests++; if (src_ready_o !== 4'b1111) begin fails++; $display("FAIL flush_empty: got %b want 1111", src_ready_o); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (wb_we_o !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL flush_leak: got %0d writebacks want 0", bad); end
    set_src(2, 1'b1, 5'd12, 64'h304);
    @(negedge clk);
    drive_idle();
    tests++; if (wb_we_o !== 1'b0) begin fails++; $display("FAIL post_flush_early: got we=%b want 0", wb_we_o); end
    @(negedge clk);
    tests++;
    if (wb_we_o !== 1'b1 || wb_dst_o !== 5'd12 || wb_data_o !== 64'h304) begin
      fails++;
      $display("FAIL post_flush_wb: got we=%b dst=%0d data=%h want we=1 dst=12 data=304", wb_we_o, wb_dst_o, wb_data_o);
    end
  endtask

  initial begin
    rstn_i = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_x0();
    test_round_robin();
    test_full_stream();
    test_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
